veririsc_ctrl: RTL and testbench
================================

# veririsc_ctrl

Instruction sequencer for the 8-bit accumulator CPU. It sits directly upstream of `alu_2` and owns the 8-phase instruction cycle, using an internal phase counter and a halt latch. Each phase, it decodes the instruction-register opcode (the same 3-bit encoding `alu_2` consumes) and the ALU's `a_is_zero` flag into the load, read, write and PC strobes for the register file, memory and program counter.

## Interface
- none (opcode width 3, phase width 3, both fixed)

- `clk`  in  1  single system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  3  instruction-register opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
- `zero`  in  1  accumulator-is-zero, wired from `alu_2.a_is_zero`
- `sel`  out  1  memory address mux: 1=PC, 0=IR operand
- `rd`  out  1  memory read enable
- `ld_ir`  out  1  instruction register load
- `inc_pc`  out  1  program counter increment
- `halt`  out  1  CPU halted
- `ld_pc`  out  1  program counter load (jump)
- `data_e`  out  1  drive accumulator onto data bus
- `ld_ac`  out  1  accumulator load from `alu_out`
- `wr`  out  1  memory write strobe
- `phase`  out  3  current phase, for debug and bench

## Operation
- State: 3-bit `phase` register and 1-bit `halted` register. All outputs are a combinational decode of `phase`, `halted`, `opcode` and `zero`.
- Phases in order, with advance by +1 mod 8:
  - 0 INST_ADDR
  - 1 INST_FETCH
  - 2 INST_LOAD
  - 3 IDLE
  - 4 OP_ADDR
  - 5 OP_FETCH
  - 6 ALU_OP
  - 7 STORE
- Wrap: 7 -> 0 unconditionally.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Output decode per phase. Any output not listed is 0.
  - 0: sel=1
  - 1: sel=1, rd=1
  - 2: sel=1, rd=1, ld_ir=1
  - 3: sel=1, rd=1, ld_ir=1
  - 4: inc_pc=1, halt=(opcode==HLT)
  - 5: rd=ALUOP
  - 6: rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO)
  - 7: rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), data_e=(opcode==STO), wr=(opcode==STO)
- `opcode` is sampled only in phases 4–7. It is a don't-care in phases 0–3, since the IR is loading then.
- `zero` is sampled only in phase 6 with SKZ.
- Halt:
  - At the edge leaving phase 4 with opcode==HLT, `halted` is set and `phase` moves to 5.
  - While `halted`=1: `phase` is frozen, `halt`=1, and every other strobe is forced to 0, regardless of `opcode`/`zero`.
  - Only `rst` clears `halted`.
- Reset: `phase`=0 and `halted`=0.
  - Outputs in and immediately after reset: sel=1, all other strobes 0, halt=0, phase=0.
  - Reset wins over any advance or halt set on the same edge, and may be asserted in any phase, including while halted.

## Timing
- Latency is 0 from `phase`/`opcode`/`zero` to strobes (pure decode). Downstream registers capture on the next rising edge.
- One phase per clock, so one instruction takes 8 clocks. The first INST_ADDR is the cycle after `rst` deasserts.
- SKZ taken: the PC is incremented twice in the instruction (phases 4 and 6).
- STO: `data_e` is high for 2 cycles (phases 6–7) and `wr` for 1 cycle (phase 7). The data bus is therefore stable one cycle before and during `wr`.
- Strobes are glitch-tolerant only: all consumers are edge-triggered on `clk`.

## Configuration
- `CTRL_STEP_EN` defined:
  - Adds input port `step` (1 bit, after `zero`).
  - `phase` advances only on edges where `step`=1; otherwise it holds. Outputs keep their decode of the held phase.
  - The halt set also requires `step`=1 at the phase-4 edge.
  - Reset still has priority.
- Not defined: no `step` port, and the phase advances every clock unless halted.

## Test plan
- Reset then run: rst=1 for 2 clocks, release, opcode=ADD.
  - Required: phase sequence 0,1,2,3,4,5,6,7,0; sel=1 exactly in phases 0–3; ld_ir=1 in phases 2–3; ld_ac=1 only in phase 7; inc_pc=1 only in phase 4.
- SKZ: opcode=SKZ, zero=1 -> inc_pc=1 in phases 4 and 6. With zero=0 -> inc_pc=1 in phase 4 only, and rd=0 in phases 5–7.
- STO: opcode=STO -> data_e=1 in phases 6–7, wr=1 in phase 7 only, rd=0 and ld_ac=0 in phases 5–7.
- JMP: opcode=JMP -> ld_pc=1 in phases 6–7, ld_ac=0 and wr=0 throughout.
- HLT:
  - opcode=HLT -> halt=1 from phase 4.
  - After that edge, phase stays at 5 for 20 clocks with all other strobes 0, even if opcode is changed to ADD.
  - rst=1 for one clock -> phase=0, halt=0, sel=1.
- Step (`CTRL_STEP_EN`):
  - step=0 for 5 clocks -> phase holds at 0.
  - step pulsed 3 times -> phase=3.
  - rst asserted with step=1 -> phase=0.

Source files
------------

// File: rtl/veririsc_ctrl.sv
// -----------------------------------------------------------------------------
// veririsc_ctrl
// Instruction sequencer for the 8-bit accumulator CPU. Steps an 8-phase
// instruction cycle and decodes the IR opcode (same 3-bit encoding as alu_2)
// plus the ALU zero flag into strobes for the register file, memory and PC.
//
// Configuration macro: CTRL_STEP_EN
//   defined   -> adds input `step`; the phase advances only on edges where
//                step=1 (the halt set also needs step=1).
//   undefined -> the phase advances every clock unless halted.
//
// Ports:
//   clk     in   system clock, all state on the rising edge
//   rst     in   synchronous active-high reset
//   opcode  in   [2:0] HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//   zero    in   accumulator-is-zero from alu_2.a_is_zero
//   step    in   single-step enable (CTRL_STEP_EN builds only)
//   sel     out  memory address mux: 1=PC, 0=IR operand
//   rd      out  memory read enable
//   ld_ir   out  instruction register load
//   inc_pc  out  program counter increment
//   halt    out  CPU halted
//   ld_pc   out  program counter load (jump)
//   data_e  out  drive accumulator onto the data bus
//   ld_ac   out  accumulator load from alu_out
//   wr      out  memory write strobe
//   phase   out  [2:0] current phase, for debug and bench
//
// The strobes are a zero-latency decode of the phase/halted state and the
// opcode/zero inputs; downstream registers capture them on the next edge.
// -----------------------------------------------------------------------------
module veririsc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef CTRL_STEP_EN
    input  logic       step,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr,
    output logic [2:0] phase
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t phase_r;
    phase_t phase_s;
    logic   halted_r;
    logic   halted_s;
    logic   advance_s;
    logic   alu_op_s;

`ifdef CTRL_STEP_EN
    assign advance_s = step;
`else
    assign advance_s = 1'b1;
`endif

    assign phase = phase_r;

    // Successor phase in the fixed 8-phase cycle; STORE wraps to INST_ADDR.
    function automatic phase_t next_phase(input phase_t cur);
        phase_t nxt;
        case (cur)
            INST_ADDR:  nxt = INST_FETCH;
            INST_FETCH: nxt = INST_LOAD;
            INST_LOAD:  nxt = IDLE;
            IDLE:       nxt = OP_ADDR;
            OP_ADDR:    nxt = OP_FETCH;
            OP_FETCH:   nxt = ALU_OP;
            ALU_OP:     nxt = STORE;
            STORE:      nxt = INST_ADDR;
            default:    nxt = INST_ADDR;
        endcase
        return nxt;
    endfunction

    // State register: phase counter and halt latch; reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r  <= INST_ADDR;
            halted_r <= 1'b0;
        end else begin
            phase_r  <= phase_s;
            halted_r <= halted_s;
        end
    end

    // Next-state: advance one phase per enabled edge, latch halt leaving OP_ADDR.
    always_comb begin
        phase_s  = phase_r;
        halted_s = halted_r;
        if (halted_r) begin
            // Frozen until reset.
            phase_s  = phase_r;
            halted_s = 1'b1;
        end else if (advance_s) begin
            phase_s = next_phase(phase_r);
            if ((phase_r == OP_ADDR) && (opcode == OP_HLT)) begin
                halted_s = 1'b1;
            end else begin
                halted_s = 1'b0;
            end
        end else begin
            phase_s  = phase_r;
            halted_s = halted_r;
        end
    end

    // Opcodes that read an operand and load the accumulator.
    always_comb begin
        case (opcode)
            OP_ADD, OP_AND, OP_XOR, OP_LDA: alu_op_s = 1'b1;
            default:                        alu_op_s = 1'b0;
        endcase
    end

    // Strobe decode of the current phase; a halted CPU asserts only halt.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (halted_r) begin
            halt = 1'b1;
        end else begin
            case (phase_r)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: begin
                    rd = alu_op_s;
                end
                ALU_OP: begin
                    // Second PC increment implements the SKZ skip.
                    rd     = alu_op_s;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    // data_e is already up one cycle before wr so the bus is settled.
                    rd     = alu_op_s;
                    ld_ac  = alu_op_s;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                    wr     = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_veririsc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_veririsc_ctrl
// Table-driven bench for veririsc_ctrl. Each row gives the inputs for one clock
// and the hand-computed phase and strobe vector expected during that clock.
// Strobe vector bit order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}.
// Hand-written sequences cover the halt freeze, reset out of halt and stepping.
// -----------------------------------------------------------------------------
module tb_veririsc_ctrl;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
`ifdef CTRL_STEP_EN
    logic       step = 1'b1;
`endif
    logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic       z;
        logic [2:0] ph;
        logic [8:0] outs;
    } vec_t;

    vec_t vecs[$];

    veririsc_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
`ifdef CTRL_STEP_EN
        .step   (step),
`endif
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .halt   (halt),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs_now();
        return {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [8:0] got, input logic [8:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s [%0d]: got %b, expected %b", name, idx, got, want);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] op, input logic z,
                       input logic [2:0] ph, input logic [8:0] o);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.ph = ph; v.outs = o;
        vecs.push_back(v);
    endtask

    // Eight rows of one instruction: fetch phases use fetch_op (don't-care),
    // execute phases use op; e4..e7 are the expected phase 4..7 strobes.
    task automatic add_instr(input logic [2:0] fetch_op, input logic [2:0] op, input logic z,
                             input logic [8:0] e4, input logic [8:0] e5,
                             input logic [8:0] e6, input logic [8:0] e7);
        add(1'b0, fetch_op, z, 3'd0, 9'b100000000);
        add(1'b0, fetch_op, z, 3'd1, 9'b110000000);
        add(1'b0, fetch_op, z, 3'd2, 9'b111000000);
        add(1'b0, fetch_op, z, 3'd3, 9'b111000000);
        add(1'b0, op,       z, 3'd4, e4);
        add(1'b0, op,       z, 3'd5, e5);
        add(1'b0, op,       z, 3'd6, e6);
        add(1'b0, op,       z, 3'd7, e7);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Second reset clock: phase 0, only sel asserted.
        add(1'b1, HLT, 1'b0, 3'd0, 9'b100000000);
        // ADD with a different opcode during fetch to show it is ignored there.
        add_instr(HLT, ADD, 1'b0, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010);
        add_instr(ADD, SKZ, 1'b1, 9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000);
        add_instr(ADD, SKZ, 1'b0, 9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000);
        add_instr(JMP, STO, 1'b1, 9'b000100000, 9'b000000000, 9'b000000100, 9'b000000101);
        add_instr(STO, JMP, 1'b1, 9'b000100000, 9'b000000000, 9'b000001000, 9'b000001000);
        // Reset in the middle of an instruction (phase 3), restart at phase 0.
        add(1'b0, XOR, 1'b0, 3'd0, 9'b100000000);
        add(1'b0, XOR, 1'b0, 3'd1, 9'b110000000);
        add(1'b0, XOR, 1'b0, 3'd2, 9'b111000000);
        add(1'b1, XOR, 1'b0, 3'd3, 9'b111000000);
        add_instr(XOR, LDA, 1'b0, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010);
        // HLT fetch and phase 4: halt rises together with inc_pc.
        add(1'b0, HLT, 1'b0, 3'd0, 9'b100000000);
        add(1'b0, HLT, 1'b0, 3'd1, 9'b110000000);
        add(1'b0, HLT, 1'b0, 3'd2, 9'b111000000);
        add(1'b0, HLT, 1'b0, 3'd3, 9'b111000000);
        add(1'b0, HLT, 1'b0, 3'd4, 9'b000110000);

        rst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            rst    = vecs[i].rst;
            opcode = vecs[i].op;
            zero   = vecs[i].z;
            #1;
            check("phase", i, {6'd0, phase}, {6'd0, vecs[i].ph});
            check("strobes", i, outs_now(), vecs[i].outs);
            @(posedge clk);
            #1;
        end

        // Halted: frozen at phase 5 with only halt, whatever opcode/zero do.
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            opcode = ADD;
            zero   = k[0];
            #1;
            check("halt_phase", k, {6'd0, phase}, 9'd5);
            check("halt_strobes", k, outs_now(), 9'b000010000);
            tick();
        end

        // One reset clock clears the halt latch.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        opcode = ADD;
        check("unhalt_phase", 0, {6'd0, phase}, 9'd0);
        check("unhalt_strobes", 0, outs_now(), 9'b100000000);
        tick();
        check("unhalt_run_phase", 1, {6'd0, phase}, 9'd1);
        check("unhalt_run_strobes", 1, outs_now(), 9'b110000000);

`ifdef CTRL_STEP_EN
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        step = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("step_hold", k, {6'd0, phase}, 9'd0);
        end
        check("step_hold_strobes", 0, outs_now(), 9'b100000000);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
        end
        check("step_count", 0, {6'd0, phase}, 9'd3);
        step = 1'b1;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        check("step_reset", 0, {6'd0, phase}, 9'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
